// File: rtl/wb_victim_cache.sv
// Fully associative victim buffer sitting beside a write-back L1 dcache.
// Holds lines evicted from L1, answers L1-miss probes (a hit hands the line
// back and frees the entry), and writes dirty lines to memory when they are
// displaced from the buffer or drained by a flush.
module wb_victim_cache #(
  parameter int NUM_ENTRIES = 4,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  // insert port (L1 eviction)
  input  logic              ins_valid_i,
  output logic              ins_ready_o,
  input  logic [ADDR_W-1:0] ins_addr_i,
  input  logic [LINE_W-1:0] ins_data_i,
  input  logic              ins_dirty_i,
  // lookup port (L1 miss probe)
  input  logic              lk_req_i,
  input  logic [ADDR_W-1:0] lk_addr_i,
  output logic              lk_ack_o,
  output logic              lk_hit_o,
  output logic [LINE_W-1:0] lk_data_o,
  output logic              lk_dirty_o,
  // flush control
  input  logic              flush_i,
  output logic              flush_done_o,
  // memory write port
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_w_data_o,
  input  logic              mem_ack_i
);

  localparam int OFFS_W = $clog2(LINE_W / 8);
  localparam int TAG_W  = ADDR_W - OFFS_W;
  localparam int IDX_W  = $clog2(NUM_ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FLUSH_SCAN,
    S_FLUSH_WB,
    S_FLUSH_DONE
  } state_t;

  state_t r_state, w_state_next;

  // Entry storage: valid/dirty are control state, tag/data are payload.
  logic [NUM_ENTRIES-1:0] r_valid;
  logic [NUM_ENTRIES-1:0] r_dirty;
  logic [TAG_W-1:0]       r_tag  [NUM_ENTRIES];
  logic [LINE_W-1:0]      r_data [NUM_ENTRIES];

  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_scan_idx;

  // Line waiting to be written to memory.
  logic [TAG_W-1:0]  r_wb_tag;
  logic [LINE_W-1:0] r_wb_data;

  // Registered lookup response.
  logic              r_lk_ack;
  logic              r_lk_hit;
  logic              r_lk_dirty;
  logic [LINE_W-1:0] r_lk_data;

  logic [TAG_W-1:0]  w_ins_tag;
  logic [TAG_W-1:0]  w_lk_tag;
  logic              w_ins_hit;
  logic [IDX_W-1:0]  w_ins_hit_idx;
  logic              w_free;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_lk_hit;
  logic [IDX_W-1:0]  w_lk_idx;
  logic [IDX_W-1:0]  w_ins_slot;
  logic              w_ins_evict;
  logic              w_evict_dirty;
  logic              w_lk_go;
  logic              w_ins_go;
  logic              w_flush_go;
  logic              w_scan_last;
  logic              w_scan_wb;
  logic              w_unused_offs;

  assign w_ins_tag = ins_addr_i[ADDR_W-1:OFFS_W];
  assign w_lk_tag  = lk_addr_i[ADDR_W-1:OFFS_W];

  // Byte-offset bits of the request addresses carry no information here.
  assign w_unused_offs = ^{ins_addr_i[OFFS_W-1:0], lk_addr_i[OFFS_W-1:0]};

  // Associative search: tag match for insert and lookup, lowest free entry.
  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    w_ins_hit     = 1'b0;
    w_ins_hit_idx = '0;
    w_free        = 1'b0;
    w_free_idx    = '0;
    w_lk_hit      = 1'b0;
    w_lk_idx      = '0;
    // Descending scan so the lowest matching/free index is the one kept.
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == w_ins_tag)) begin
        w_ins_hit     = 1'b1;
        w_ins_hit_idx = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_valid[i] && (r_tag[i] == w_lk_tag)) begin
        w_lk_hit = 1'b1;
        w_lk_idx = IDX_W'(i);
      end
    end
  end

  // Slot choice: merge into an existing copy, else a free slot, else round-robin victim.
  always_comb begin
    w_ins_slot  = r_rr_ptr;
    w_ins_evict = 1'b0;
    if (w_ins_hit) begin
      w_ins_slot = w_ins_hit_idx;
    end else if (w_free) begin
      w_ins_slot = w_free_idx;
    end else begin
      w_ins_evict = 1'b1;
    end
  end

  assign w_evict_dirty = w_ins_evict && r_dirty[r_rr_ptr];

  // Lookup has priority over insert; a lookup is never serviced in the
  // cycle its previous ack is visible, so a held request re-probes later.
  assign w_lk_go     = (r_state == S_IDLE) && lk_req_i && !r_lk_ack;
  assign w_ins_go    = ins_valid_i && ins_ready_o;
  assign w_flush_go  = (r_state == S_IDLE) && flush_i && !lk_req_i && !ins_valid_i;
  assign w_scan_last = (r_scan_idx == IDX_W'(NUM_ENTRIES - 1));
  assign w_scan_wb   = r_valid[r_scan_idx] && r_dirty[r_scan_idx];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    ins_ready_o  = 1'b0;
    mem_req_o    = 1'b0;
    flush_done_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        ins_ready_o = !lk_req_i;
        if (w_ins_go && w_evict_dirty) w_state_next = S_WB;
        else if (w_flush_go)           w_state_next = S_FLUSH_SCAN;
      end
      S_WB: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) w_state_next = S_IDLE;
      end
      S_FLUSH_SCAN: begin
        if (w_scan_wb)        w_state_next = S_FLUSH_WB;
        else if (w_scan_last) w_state_next = S_FLUSH_DONE;
      end
      S_FLUSH_WB: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) w_state_next = w_scan_last ? S_FLUSH_DONE : S_FLUSH_SCAN;
      end
      S_FLUSH_DONE: begin
        flush_done_o = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Control state: entry valid/dirty bits, pointers and the lookup response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= '0;
      r_dirty    <= '0;
      r_rr_ptr   <= '0;
      r_scan_idx <= '0;
      r_lk_ack   <= 1'b0;
      r_lk_hit   <= 1'b0;
      r_lk_dirty <= 1'b0;
      r_lk_data  <= '0;
    end else begin
      r_lk_ack   <= w_lk_go;
      r_lk_hit   <= w_lk_go && w_lk_hit;
      r_lk_dirty <= w_lk_go && w_lk_hit && r_dirty[w_lk_idx];
      r_lk_data  <= (w_lk_go && w_lk_hit) ? r_data[w_lk_idx] : '0;

      // A lookup hit swaps the line back to L1, so the entry is released.
      if (w_lk_go && w_lk_hit) r_valid[w_lk_idx] <= 1'b0;

      if (w_ins_go) begin
        r_valid[w_ins_slot] <= 1'b1;
        r_dirty[w_ins_slot] <= (w_ins_hit && r_dirty[w_ins_slot]) || ins_dirty_i;
        if (w_ins_evict) r_rr_ptr <= r_rr_ptr + 1'b1;
      end

      if (w_flush_go) r_scan_idx <= '0;

      if (r_state == S_FLUSH_SCAN) begin
        r_valid[r_scan_idx] <= 1'b0;
        r_dirty[r_scan_idx] <= 1'b0;
        if (!w_scan_wb && !w_scan_last) r_scan_idx <= r_scan_idx + 1'b1;
      end

      if ((r_state == S_FLUSH_WB) && mem_ack_i && !w_scan_last)
        r_scan_idx <= r_scan_idx + 1'b1;
    end
  end

  // Payload storage and writeback buffer.
  // NOTE: tag/data arrays are deliberately not reset; the valid bits gate
  // every use, and leaving wide storage out of reset keeps it plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_ins_go) begin
      r_tag[w_ins_slot]  <= w_ins_tag;
      r_data[w_ins_slot] <= ins_data_i;
    end
    if (w_ins_go && w_evict_dirty) begin
      r_wb_tag  <= r_tag[r_rr_ptr];
      r_wb_data <= r_data[r_rr_ptr];
    end
    if ((r_state == S_FLUSH_SCAN) && w_scan_wb) begin
      r_wb_tag  <= r_tag[r_scan_idx];
      r_wb_data <= r_data[r_scan_idx];
    end
  end

  assign lk_ack_o     = r_lk_ack;
  assign lk_hit_o     = r_lk_hit;
  assign lk_dirty_o   = r_lk_dirty;
  assign lk_data_o    = r_lk_data;
  assign mem_addr_o   = mem_req_o ? {r_wb_tag, {OFFS_W{1'b0}}} : '0;
  assign mem_w_data_o = mem_req_o ? r_wb_data : '0;

endmodule

// File: tb/tb_wb_victim_cache.sv
// Self-checking bench for wb_victim_cache: directed scenarios plus a random
// mix of inserts, lookups and flushes checked against a behavioural model.
module tb_wb_victim_cache;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int LW   = 128;
  localparam int OFFS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ins_valid_i = 1'b0;
  logic          ins_ready_o;
  logic [AW-1:0] ins_addr_i = '0;
  logic [LW-1:0] ins_data_i = '0;
  logic          ins_dirty_i = 1'b0;
  logic          lk_req_i = 1'b0;
  logic [AW-1:0] lk_addr_i = '0;
  logic          lk_ack_o;
  logic          lk_hit_o;
  logic [LW-1:0] lk_data_o;
  logic          lk_dirty_o;
  logic          flush_i = 1'b0;
  logic          flush_done_o;
  logic          mem_req_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_w_data_o;
  logic          mem_ack_i;

  wb_victim_cache #(.NUM_ENTRIES(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ins_valid_i  (ins_valid_i),
    .ins_ready_o  (ins_ready_o),
    .ins_addr_i   (ins_addr_i),
    .ins_data_i   (ins_data_i),
    .ins_dirty_i  (ins_dirty_i),
    .lk_req_i     (lk_req_i),
    .lk_addr_i    (lk_addr_i),
    .lk_ack_o     (lk_ack_o),
    .lk_hit_o     (lk_hit_o),
    .lk_data_o    (lk_data_o),
    .lk_dirty_o   (lk_dirty_o),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_w_data_o (mem_w_data_o),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit            v;
    bit            d;
    logic [AW-1:0] a;
    logic [LW-1:0] data;
  } ent_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [LW-1:0] d;
  } wr_t;

  ent_t m[N];
  int   m_rr;
  wr_t  exp_wr[$];
  wr_t  got_wr[$];

  int n_checks = 0;
  int n_pass   = 0;

  bit resp_en  = 1'b0;
  int resp_lat = 0;
  int resp_cnt = 0;

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return {a[AW-1:OFFS], {OFFS{1'b0}}};
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m[i].v = 1'b0; m[i].d = 1'b0; m[i].a = '0; m[i].data = '0;
    end
    m_rr = 0;
  endfunction

  function automatic void m_insert(input logic [AW-1:0] a, input logic [LW-1:0] d, input bit dirty);
    int slot = -1;
    for (int i = 0; i < N; i++)
      if (m[i].v && m[i].a == line_of(a)) slot = i;
    if (slot >= 0) begin
      m[slot].data = d;
      m[slot].d    = m[slot].d | dirty;
      return;
    end
    for (int i = N - 1; i >= 0; i--)
      if (!m[i].v) slot = i;
    if (slot < 0) begin
      slot = m_rr;
      if (m[slot].d) exp_wr.push_back('{m[slot].a, m[slot].data});
      m_rr = (m_rr + 1) % N;
    end
    m[slot].v = 1'b1; m[slot].d = dirty; m[slot].a = line_of(a); m[slot].data = d;
  endfunction

  function automatic void m_lookup(input logic [AW-1:0] a, output bit hit, output logic [LW-1:0] d, output bit dirty);
    hit = 1'b0; d = '0; dirty = 1'b0;
    for (int i = 0; i < N; i++)
      if (m[i].v && m[i].a == line_of(a)) begin
        hit = 1'b1; d = m[i].data; dirty = m[i].d; m[i].v = 1'b0;
      end
  endfunction

  function automatic void m_flush();
    for (int i = 0; i < N; i++) begin
      if (m[i].v && m[i].d) exp_wr.push_back('{m[i].a, m[i].data});
      m[i].v = 1'b0; m[i].d = 1'b0;
    end
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    mem_ack_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        if (mem_ack_i) mem_ack_i = 1'b0;
        else if (mem_req_o) begin
          if (resp_cnt >= resp_lat) begin
            mem_ack_i = 1'b1;
            got_wr.push_back('{mem_addr_o, mem_w_data_o});
            resp_cnt = 0;
          end else resp_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    rst_n = 1'b0; ins_valid_i = 1'b0; lk_req_i = 1'b0; flush_i = 1'b0;
    resp_en = 1'b0; resp_cnt = 0; mem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    exp_wr.delete(); got_wr.delete();
  endtask

  task automatic do_insert(input logic [AW-1:0] a, input logic [LW-1:0] d, input bit dirty);
    bit acc = 1'b0;
    ins_addr_i = a; ins_data_i = d; ins_dirty_i = dirty; ins_valid_i = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      acc = ins_ready_o;
      @(posedge clk); #1;
    end
    ins_valid_i = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL insert_timeout: addr %h never accepted within 200 cycles", a);
    end else m_insert(a, d, dirty);
  endtask

  task automatic do_lookup(input logic [AW-1:0] a, output int lat);
    bit            got = 1'b0;
    bit            e_hit, e_dirty;
    logic [LW-1:0] e_data;
    lat = 0;
    m_lookup(a, e_hit, e_data, e_dirty);
    lk_addr_i = a; lk_req_i = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk); #1;
      lat++;
      got = lk_ack_o;
    end
    lk_req_i = 1'b0;
    n_checks++;
    if (!got) $display("FAIL lookup_timeout: addr %h no ack within 200 cycles", a);
    else begin
      n_pass++;
      n_checks++;
      if (lk_hit_o !== e_hit) $display("FAIL lookup_hit: addr %h got %b expected %b", a, lk_hit_o, e_hit);
      else n_pass++;
      if (e_hit) begin
        n_checks++;
        if (lk_data_o !== e_data) $display("FAIL lookup_data: addr %h got %h expected %h", a, lk_data_o, e_data);
        else n_pass++;
        n_checks++;
        if (lk_dirty_o !== e_dirty) $display("FAIL lookup_dirty: addr %h got %b expected %b", a, lk_dirty_o, e_dirty);
        else n_pass++;
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (lk_ack_o !== 1'b0) $display("FAIL lookup_ack_pulse: ack got %b expected 0", lk_ack_o);
    else n_pass++;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!ins_ready_o && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ins_ready_o) begin
      n_checks++;
      $display("FAIL idle_timeout: ins_ready got 0 expected 1 after 500 cycles");
    end
  endtask

  task automatic do_flush();
    bit seen = 1'b0;
    wait_idle();
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    m_flush();
    for (int k = 0; k < 500 && !seen; k++) begin
      if (flush_done_o) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    n_checks++;
    if (!seen) $display("FAIL flush_done_timeout: done got 0 expected 1 within 500 cycles");
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (flush_done_o !== 1'b0) $display("FAIL flush_done_pulse: got %b expected 0", flush_done_o);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_req_o, lk_ack_o, lk_hit_o, lk_dirty_o, flush_done_o} !== 5'b0)
      $display("FAIL reset_ctrl: {req,ack,hit,dirty,done} got %b expected 00000",
               {mem_req_o, lk_ack_o, lk_hit_o, lk_dirty_o, flush_done_o});
    else n_pass++;
    n_checks++;
    if ({lk_data_o, mem_addr_o, mem_w_data_o} !== '0) $display("FAIL reset_data: data/addr outputs not 0");
    else n_pass++;
    n_checks++;
    if (ins_ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ins_ready_o);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_lookup_basic();
    int lat;
    logic [AW-1:0] a = 32'h0001_2340;
    logic [LW-1:0] d = 128'hDEAD_0123_4567_89AB_CDEF_0F1E_2D3C_BEEF;
    apply_reset();
    do_insert(a, d, 1'b1);
    do_lookup(a, lat);
    n_checks++;
    if (lat !== 1) $display("FAIL lookup_latency: got %0d expected 1", lat);
    else n_pass++;
    do_lookup(a, lat);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a = 32'h0000_5670;
    bit ok;
    apply_reset();
    do_insert(a, 128'h1234, 1'b1);
    lk_addr_i = a; lk_req_i = 1'b1;
    @(posedge clk); #1;
    ok = lk_ack_o && lk_hit_o && lk_dirty_o;
    @(posedge clk); #1;
    ok = ok && !lk_ack_o;
    @(posedge clk); #1;
    ok = ok && lk_ack_o && !lk_hit_o;
    lk_req_i = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL held_lookup: ack/hit sequence got ack=%b hit=%b at end, expected hit,gap,miss", lk_ack_o, lk_hit_o);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_replace();
    int lat;
    bit quiet = 1'b1;
    apply_reset();
    for (int i = 0; i < 5; i++) do_insert(32'h0010_0000 + 32'(i * 16), 128'(32'hC000 + i), 1'b0);
    repeat (3) begin
      quiet = quiet && !mem_req_o;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!quiet) $display("FAIL clean_no_wb: mem_req got 1 expected 0");
    else n_pass++;
    do_lookup(32'h0010_0000, lat);
    do_lookup(32'h0010_0040, lat);
  endtask

  task automatic test_dirty_evict();
    int lat;
    wr_t w;
    apply_reset();
    for (int i = 0; i < 5; i++) do_insert(32'h0020_0000 + 32'(i * 16) + 32'(i), {4{32'hD000 + 32'(i)}}, 1'b1);
    w = exp_wr.pop_front();
    n_checks++;
    if (mem_req_o !== 1'b1) $display("FAIL evict_req: got %b expected 1", mem_req_o);
    else n_pass++;
    n_checks++;
    if (mem_addr_o !== w.a || mem_w_data_o !== w.d)
      $display("FAIL evict_payload: addr %h data %h expected %h %h", mem_addr_o, mem_w_data_o, w.a, w.d);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (mem_req_o !== 1'b1 || ins_ready_o !== 1'b0)
        $display("FAIL evict_hold: cycle %0d req %b ready %b expected 1 0", c, mem_req_o, ins_ready_o);
      else n_pass++;
      if (c < 2) begin @(posedge clk); #1; end
    end
    mem_ack_i = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    n_checks++;
    if (mem_req_o !== 1'b0 || ins_ready_o !== 1'b1)
      $display("FAIL evict_release: req %b ready %b expected 0 1", mem_req_o, ins_ready_o);
    else n_pass++;
    // Stray ack with nothing outstanding must not disturb anything.
    mem_ack_i = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (mem_req_o !== 1'b0 || ins_ready_o !== 1'b1)
      $display("FAIL stray_ack: req %b ready %b expected 0 1", mem_req_o, ins_ready_o);
    else n_pass++;
    do_lookup(32'h0020_0010, lat);
    do_lookup(32'h0020_0000, lat);
  endtask

  task automatic test_flush();
    int lat;
    apply_reset();
    resp_en = 1'b1; resp_lat = 2;
    for (int i = 0; i < 4; i++) do_insert(32'h0030_0000 + 32'(i * 16), {4{32'hF000 + 32'(i)}}, (i % 2) == 1);
    do_flush();
    n_checks++;
    if (got_wr.size() !== exp_wr.size()) $display("FAIL flush_wr_count: got %0d expected %0d", got_wr.size(), exp_wr.size());
    else n_pass++;
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      n_checks++;
      if (got_wr[i] !== exp_wr[i]) $display("FAIL flush_wr_%0d: addr %h expected %h", i, got_wr[i].a, exp_wr[i].a);
      else n_pass++;
    end
    exp_wr.delete(); got_wr.delete();
    for (int i = 0; i < 4; i++) do_lookup(32'h0030_0000 + 32'(i * 16), lat);
  endtask

  task automatic test_merge();
    int lat;
    bit quiet = 1'b1;
    apply_reset();
    do_insert(32'h0040_0120, 128'hAAAA, 1'b1);
    do_insert(32'h0040_0128, 128'hBBBB_CCCC, 1'b0);
    repeat (3) begin
      quiet = quiet && !mem_req_o;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!quiet) $display("FAIL merge_no_wb: mem_req got 1 expected 0");
    else n_pass++;
    do_lookup(32'h0040_0120, lat);
    do_lookup(32'h0040_0120, lat);
  endtask

  task automatic test_flush_insert();
    apply_reset();
    resp_en = 1'b1; resp_lat = 1;
    ins_addr_i = 32'h0050_0000; ins_data_i = 128'h5555_6666; ins_dirty_i = 1'b1;
    ins_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    ins_valid_i = 1'b0;
    m_insert(32'h0050_0000, 128'h5555_6666, 1'b1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    m_flush();
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
        if (flush_done_o) seen = 1'b1;
        else begin @(posedge clk); #1; end
      end
      n_checks++;
      if (!seen) $display("FAIL flush_insert_done: done got 0 expected 1 within 100 cycles");
      else n_pass++;
    end
    n_checks++;
    if (got_wr.size() !== 1 || exp_wr.size() !== 1 || got_wr[0] !== exp_wr[0])
      $display("FAIL flush_insert_wr: got %0d writes expected 1 of the inserted line", got_wr.size());
    else n_pass++;
    exp_wr.delete(); got_wr.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    apply_reset();
    for (int i = 0; i < 5; i++) do_insert(32'h0060_0000 + 32'(i * 16), {4{32'h6000 + 32'(i)}}, 1'b1);
    n_checks++;
    if (mem_req_o !== 1'b1) $display("FAIL midreset_pre: req got %b expected 1", mem_req_o);
    else n_pass++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (mem_req_o !== 1'b0) $display("FAIL midreset_req: got %b expected 0", mem_req_o);
    else n_pass++;
    rst_n = 1'b1;
    m_reset(); exp_wr.delete();
    for (int i = 0; i < 5; i++) do_lookup(32'h0060_0000 + 32'(i * 16), lat);
    lk_addr_i = 32'h0060_0010; lk_req_i = 1'b1;
    ins_addr_i = 32'h0061_0000; ins_data_i = 128'h77; ins_dirty_i = 1'b0; ins_valid_i = 1'b1;
    #1;
    n_checks++;
    if (ins_ready_o !== 1'b0) $display("FAIL lk_over_ins_ready: got %b expected 0", ins_ready_o);
    else n_pass++;
    @(posedge clk); #1;
    lk_req_i = 1'b0; ins_valid_i = 1'b0;
    @(posedge clk); #1;
    do_lookup(32'h0061_0000, lat);
  endtask

  task automatic test_random();
    int lat;
    apply_reset();
    resp_en = 1'b1;
    for (int op = 0; op < 300; op++) begin
      int r = $urandom_range(0, 19);
      logic [AW-1:0] a = 32'h1000_0000 + ($urandom_range(0, 7) << 4) + $urandom_range(0, 15);
      resp_lat = $urandom_range(0, 3);
      if (r < 10)      do_insert(a, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
      else if (r < 19) do_lookup(a, lat);
      else             do_flush();
    end
    wait_idle();
    n_checks++;
    if (got_wr.size() !== exp_wr.size()) $display("FAIL rand_wr_count: got %0d expected %0d", got_wr.size(), exp_wr.size());
    else n_pass++;
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      n_checks++;
      if (got_wr[i] !== exp_wr[i])
        $display("FAIL rand_wr_%0d: addr %h data %h expected %h %h", i, got_wr[i].a, got_wr[i].d, exp_wr[i].a, exp_wr[i].d);
      else n_pass++;
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_lookup_basic();
    test_back_to_back();
    test_clean_replace();
    test_dirty_evict();
    test_flush();
    test_merge();
    test_flush_insert();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
